// File: rtl/pe_addr_tracer.sv
// Multi-channel address trace recorder for PE operand ports, with freeze-on-full or circular capture.
// Define PE_TRACE_TIMESTAMP_EN to store a 32-bit capture-cycle timestamp in the MSBs of every entry.
module pe_addr_tracer #(
    parameter  int NUM_CH    = 3,
    parameter  int ADDR_W    = 32,
    parameter  int DEPTH     = 1024,
    parameter  int WRAP_MODE = 0,
    parameter  int CNT_W     = $clog2(DEPTH) + 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W     = $clog2(DEPTH),
`ifdef PE_TRACE_TIMESTAMP_EN
    localparam int TS_W      = 32,
`else
    localparam int TS_W      = 0,
`endif
    localparam int E_W       = ADDR_W + 1 + TS_W
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [NUM_CH-1:0]        ch_ce,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic                     rd_en,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic                     rd_valid,
    output logic [E_W-1:0]           rd_data,
    output logic [NUM_CH*CNT_W-1:0]  cnt,
    output logic [NUM_CH-1:0]        overflow,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   wr_ptr [NUM_CH];
    logic [CNT_W-1:0]   cnt_r  [NUM_CH];
    logic [NUM_CH-1:0]  ovf_r;
    logic [NUM_CH-1:0]  wr_en;
    logic [NUM_CH-1:0]  at_last;
    logic               full_hit;
    logic [CH_W-1:0]    rd_ch_q;
    logic               rd_seen;
    logic [E_W-1:0]     rd_word [NUM_CH];
`ifdef PE_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]    ts_r;
`endif

    // The arm cycle itself never records: arm restarts the pointers that edge.
    always_comb begin
        wr_en   = (state == ST_CAPTURE && !arm) ? ch_ce : '0;
        at_last = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            at_last[k] = (wr_ptr[k] == IDX_W'(DEPTH - 1));
        end
        full_hit = (WRAP_MODE == 0) && |(wr_en & at_last);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= ST_IDLE;
            ovf_r    <= '0;
            rd_valid <= 1'b0;
            rd_seen  <= 1'b0;
            rd_ch_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                cnt_r[k]  <= '0;
            end
`ifdef PE_TRACE_TIMESTAMP_EN
            ts_r <= '0;
`endif
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_ch_q <= rd_ch;
                rd_seen <= 1'b1;
            end
            if (arm) begin
                state <= ST_CAPTURE;
                ovf_r <= '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    wr_ptr[k] <= '0;
                    cnt_r[k]  <= '0;
                end
`ifdef PE_TRACE_TIMESTAMP_EN
                ts_r <= '0;
`endif
            end else if (state == ST_CAPTURE) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (wr_en[k]) begin
                        wr_ptr[k] <= wr_ptr[k] + IDX_W'(1);
                        if (cnt_r[k] != CNT_W'(DEPTH)) begin
                            cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                        end
                        if (at_last[k]) begin
                            ovf_r[k] <= 1'b1;
                        end
                    end
                end
`ifdef PE_TRACE_TIMESTAMP_EN
                ts_r <= ts_r + TS_W'(1);
`endif
                if (stop || full_hit) begin
                    state <= ST_FROZEN;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [E_W-1:0]   mem [DEPTH];
        logic [E_W-1:0]   ram_q;
        logic [E_W-1:0]   wr_word;
        logic [IDX_W-1:0] phys;

        // Once a circular buffer has wrapped, the write pointer marks the oldest entry.
        always_comb begin
            phys = (WRAP_MODE != 0 && ovf_r[k]) ? wr_ptr[k] + rd_idx : rd_idx;
`ifdef PE_TRACE_TIMESTAMP_EN
            wr_word = {ts_r, ch_we[k], ch_addr[k*ADDR_W +: ADDR_W]};
`else
            wr_word = {ch_we[k], ch_addr[k*ADDR_W +: ADDR_W]};
`endif
        end

        always_ff @(posedge ap_clk) begin
            if (wr_en[k]) begin
                mem[wr_ptr[k]] <= wr_word;
            end
            if (rd_en) begin
                ram_q <= mem[phys];
            end
        end

        assign rd_word[k]                 = ram_q;
        assign cnt[k*CNT_W +: CNT_W]      = cnt_r[k];
    end

    always_comb begin
        rd_data = '0;
        if (rd_seen && int'(rd_ch_q) < NUM_CH) begin
            rd_data = rd_word[rd_ch_q];
        end
    end

    assign overflow  = ovf_r;
    assign busy      = (state == ST_CAPTURE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pe_addr_tracer.sv
// Bench for pe_addr_tracer: a freeze-mode and a wrap-mode instance share stimulus and are
// checked against a history-based reference model of what each trace buffer should hold.
module tb_pe_addr_tracer;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
`ifdef PE_TRACE_TIMESTAMP_EN
    localparam int E_W    = ADDR_W + 1 + 32;
`else
    localparam int E_W    = ADDR_W + 1;
`endif
    localparam int HMAX   = 128;

    // clock/reset
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    logic                     arm = 1'b0;
    logic                     stop = 1'b0;
    logic [NUM_CH-1:0]        ch_ce = '0;
    logic [NUM_CH-1:0]        ch_we = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
    logic                     rd_en = 1'b0;
    logic [1:0]               rd_ch = '0;
    logic [2:0]               rd_idx = '0;

    logic                     rd_valid_o [2];
    logic [E_W-1:0]           rd_data_o  [2];
    logic [NUM_CH*CNT_W-1:0]  cnt_o      [2];
    logic [NUM_CH-1:0]        ovf_o      [2];
    logic                     busy_o     [2];
    logic [1:0]               st_o       [2];

    pe_addr_tracer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WRAP_MODE(0)) u_frz (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .arm(arm), .stop(stop),
        .ch_ce(ch_ce), .ch_we(ch_we), .ch_addr(ch_addr),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx),
        .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]), .cnt(cnt_o[0]),
        .overflow(ovf_o[0]), .busy(busy_o[0]), .state_dbg(st_o[0])
    );

    pe_addr_tracer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WRAP_MODE(1)) u_wrp (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .arm(arm), .stop(stop),
        .ch_ce(ch_ce), .ch_we(ch_we), .ch_addr(ch_addr),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx),
        .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]), .cnt(cnt_o[1]),
        .overflow(ovf_o[1]), .busy(busy_o[1]), .state_dbg(st_o[1])
    );

    // reference model: every access since the last arm, oldest first
    int          mst [2];            // 0 idle, 1 capturing, 2 stopped
    int          nwr [2][NUM_CH];
    int unsigned mts [2];
    logic [E_W-1:0] hist [2][NUM_CH][HMAX];

    // scoreboard
    logic [E_W-1:0] exp_q [$];
    bit             care_q [$];
    logic [E_W-1:0] last_rd [2];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt(int m, int k);
        return (nwr[m][k] > DEPTH) ? DEPTH : nwr[m][k];
    endfunction

    function automatic logic [E_W-1:0] m_read(int m, int k, int idx, output bit care);
        int sz;
        sz   = m_cnt(m, k);
        care = (idx < sz);
        if (care) return hist[m][k][nwr[m][k] - sz + idx];
        return '0;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (ap_rst) begin
                mst[m] = 0;
                mts[m] = 0;
                for (int k = 0; k < NUM_CH; k++) nwr[m][k] = 0;
            end else if (arm) begin
                mst[m] = 1;
                mts[m] = 0;
                for (int k = 0; k < NUM_CH; k++) nwr[m][k] = 0;
            end else if (mst[m] == 1) begin
                bit filled = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_ce[k]) begin
`ifdef PE_TRACE_TIMESTAMP_EN
                        if (nwr[m][k] < HMAX) hist[m][k][nwr[m][k]] = {mts[m], ch_we[k], ch_addr[k*ADDR_W +: ADDR_W]};
`else
                        if (nwr[m][k] < HMAX) hist[m][k][nwr[m][k]] = {ch_we[k], ch_addr[k*ADDR_W +: ADDR_W]};
`endif
                        nwr[m][k]++;
                        if (nwr[m][k] == DEPTH) filled = 1;
                    end
                end
                mts[m]++;
                if (stop || (m == 0 && filled)) mst[m] = 2;
            end
        end
    endtask

    task automatic check_status();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("busy m%0d", m), busy_o[m], mst[m] == 1);
            for (int k = 0; k < NUM_CH; k++) begin
                chk($sformatf("cnt m%0d ch%0d", m, k), cnt_o[m][k*CNT_W +: CNT_W], m_cnt(m, k));
                chk($sformatf("ovf m%0d ch%0d", m, k), ovf_o[m][k], nwr[m][k] >= DEPTH);
            end
        end
    endtask

    // one clock: queue read expectations, advance the model, clock, check, release pulses
    task automatic cyc();
        bit did_rd;
        did_rd = rd_en;
        if (rd_en) begin
            for (int m = 0; m < 2; m++) begin
                bit care;
                logic [E_W-1:0] v;
                v = m_read(m, int'(rd_ch), int'(rd_idx), care);
                exp_q.push_back(v);
                care_q.push_back(care);
            end
        end
        model_edge();
        @(posedge ap_clk);
        #1;
        arm = 0; stop = 0; ch_ce = '0; ch_we = '0; rd_en = 0;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rd_valid m%0d", m), rd_valid_o[m], did_rd);
            last_rd[m] = rd_data_o[m];
            if (did_rd) begin
                logic [E_W-1:0] e;
                bit c;
                e = exp_q.pop_front();
                c = care_q.pop_front();
                if (c) chk($sformatf("rd_data m%0d ch%0d idx%0d", m, rd_ch, rd_idx), rd_data_o[m], e);
            end
        end
        check_status();
    endtask

    // driver tasks
    task automatic set_acc(input int ch, input bit we, input logic [ADDR_W-1:0] addr);
        ch_ce[ch] = 1'b1;
        ch_we[ch] = we;
        ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    endtask

    task automatic do_arm();
        arm = 1;
        cyc();
    endtask

    task automatic do_read(input int ch, input int idx);
        rd_en  = 1;
        rd_ch  = 2'(ch);
        rd_idx = 3'(idx);
        cyc();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mst[m] = 0; mts[m] = 0;
            for (int k = 0; k < NUM_CH; k++) nwr[m][k] = 0;
        end

        // reset
        ap_rst = 1;
        repeat (3) cyc();
        ap_rst = 0;
        for (int m = 0; m < 2; m++) begin
            chk("rst rd_data", rd_data_o[m], 0);
            chk("rst rd_valid", rd_valid_o[m], 0);
            chk("rst cnt", cnt_o[m], 0);
            chk("rst ovf", ovf_o[m], 0);
            chk("rst busy", busy_o[m], 0);
        end

        // reset mid-capture, then a fresh arm records from index 0
        do_arm();
        for (int i = 0; i < 5; i++) begin set_acc(0, 0, 32'(i + 40)); cyc(); end
        ap_rst = 1;
        cyc();
        ap_rst = 0;
        chk("midrst busy", busy_o[0], 0);
        chk("midrst cnt", cnt_o[1], 0);
        chk("midrst ovf", ovf_o[0], 0);
        do_arm();
        set_acc(0, 0, 32'h99); cyc();
        stop = 1; cyc();
        do_read(0, 0);
        chk("rearm idx0", last_rd[0][ADDR_W:0], 33'h99);

        // basic capture: ch1 streams reads, ch2 does one write
        do_arm();
        for (int i = 0; i < 7; i++) begin
            set_acc(1, 0, 32'(i));
            if (i == 2) set_acc(2, 1, 32'd3);
            cyc();
        end
        stop = 1; cyc();
        chk("basic busy", busy_o[0], 0);
        chk("basic cnt1", cnt_o[0][1*CNT_W +: CNT_W], 7);
        chk("basic cnt2", cnt_o[0][2*CNT_W +: CNT_W], 1);
        do_read(1, 5);
        chk("basic ch1 idx5", last_rd[0][ADDR_W:0], 33'd5);
        do_read(2, 0);
        chk("basic ch2 idx0", last_rd[0][ADDR_W:0], {1'b1, 32'd3});
        cyc();

        // freeze on full: ch0 fills, ch1 runs one access behind
        do_arm();
        for (int i = 0; i < 8; i++) begin
            set_acc(0, 0, 32'(100 + i));
            if (i > 0) set_acc(1, 1, 32'(200 + i));
            cyc();
        end
        chk("frz ovf", ovf_o[0], 3'b001);
        chk("frz busy", busy_o[0], 0);
        chk("frz cnt0", cnt_o[0][0 +: CNT_W], 8);
        chk("frz cnt1", cnt_o[0][CNT_W +: CNT_W], 7);
        for (int i = 0; i < 2; i++) begin set_acc(0, 0, 32'(300 + i)); set_acc(1, 0, 32'(400 + i)); cyc(); end
        chk("frz cnt0 hold", cnt_o[0][0 +: CNT_W], 8);
        chk("frz cnt1 hold", cnt_o[0][CNT_W +: CNT_W], 7);
        stop = 1; cyc();
        for (int i = 0; i < 8; i += 3) do_read(0, i);
        do_read(1, 6);

        // circular capture: 11 accesses into 8 entries
        do_arm();
        for (int i = 0; i < 11; i++) begin set_acc(0, 0, 32'(i)); cyc(); end
        stop = 1; cyc();
        chk("wrp cnt0", cnt_o[1][0 +: CNT_W], 8);
        chk("wrp ovf0", ovf_o[1][0], 1);
        do_read(0, 0);
        chk("wrp idx0", last_rd[1][ADDR_W:0], 33'd3);
        do_read(0, 7);
        chk("wrp idx7", last_rd[1][ADDR_W:0], 33'd10);
        do_read(0, 4);

        // simultaneous events
        arm = 1; stop = 1; cyc();
        chk("arm+stop busy", busy_o[0], 1);
        stop = 1; set_acc(0, 0, 32'h55); cyc();
        chk("stop+acc cnt0", cnt_o[0][0 +: CNT_W], 1);
        chk("stop+acc busy", busy_o[1], 0);
        do_read(0, 0);
        chk("stop+acc data", last_rd[1][ADDR_W:0], 33'h55);

`ifdef PE_TRACE_TIMESTAMP_EN
        do_arm();
        set_acc(0, 0, 32'hA0); cyc();
        cyc(); cyc();
        set_acc(0, 1, 32'hA1); cyc();
        stop = 1; cyc();
        begin
            logic [31:0] t0, t1;
            do_read(0, 0);
            t0 = last_rd[0][ADDR_W+1 +: 32];
            do_read(0, 1);
            t1 = last_rd[0][ADDR_W+1 +: 32];
            chk("ts first", t0, 0);
            chk("ts delta", t1 - t0, 3);
        end
`endif

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            do_arm();
            for (int c = 0; c < 30; c++) begin
                ch_ce = 3'($urandom_range(0, 7));
                ch_we = 3'($urandom_range(0, 7));
                for (int k = 0; k < NUM_CH; k++) ch_addr[k*ADDR_W +: ADDR_W] = $urandom;
                if ($urandom_range(0, 5) == 0) begin
                    rd_en = 1; rd_ch = 2'($urandom_range(0, 2)); rd_idx = 3'($urandom_range(0, 7));
                end
                if (c > 20 && $urandom_range(0, 9) == 0) stop = 1;
                cyc();
            end
            stop = 1; cyc();
            for (int i = 0; i < 10; i++) do_read($urandom_range(0, 2), $urandom_range(0, 7));
        end
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
